// File: rtl/fractal_scheduler_if.sv
// -----------------------------------------------------------------------------
// fractal_scheduler_if
//   Pixel-in / result-out stream bundle of the fractal slot scheduler.
//
//   Handshake rule for both streams: a transfer happens on a rising clk edge
//   where valid && ready are both high. The sender holds its payload stable
//   while valid is high and ready is low. ready never depends on valid.
//
//   Signals
//     s_valid / s_ready : new pixel stream (coordinate generator -> scheduler)
//     s_cr, s_ci        : c of the new pixel, signed Q4.28
//     s_tag             : pixel index carried with the pixel
//     m_valid / m_ready : result stream (scheduler -> pixel writer)
//     m_tag, m_iter     : tag and final iteration count of a retired pixel
//
//   Modports
//     master : the environment side (drives pixels, consumes results)
//     slave  : the scheduler side
// -----------------------------------------------------------------------------
interface fractal_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 20
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_cr;
  logic [DATA_WIDTH-1:0] s_ci;
  logic [TAG_WIDTH-1:0]  s_tag;
  logic                  m_valid;
  logic                  m_ready;
  logic [TAG_WIDTH-1:0]  m_tag;
  logic [7:0]            m_iter;

  modport master (
    output s_valid, s_cr, s_ci, s_tag, m_ready,
    input  s_ready, m_valid, m_tag, m_iter
  );

  modport slave (
    input  s_valid, s_cr, s_ci, s_tag, m_ready,
    output s_ready, m_valid, m_tag, m_iter
  );
endinterface

// File: rtl/fractal_scheduler.sv
// -----------------------------------------------------------------------------
// fractal_scheduler
//   Time-multiplexes one fractal_kernel pipeline (latency PIPELINE_DEPTH)
//   among many pixels. Every cycle owns one issue slot: the pixel returning
//   from the kernel is either sent round again, retired to the result port,
//   or (when the slot is free) replaced by a new pixel from the input stream.
//   A shadow shift register of valid bits and tags runs alongside the kernel
//   so that its last stage lines up with the kernel outputs of the same cycle.
//
//   Ports
//     clk, rst          : clock, asynchronous active-high reset
//     bus (slave)       : pixel input stream and result output stream
//     k_*_in            : issue-slot values driven into the kernel
//     k_*_out           : values returning from the kernel this cycle
//     in_flight         : valid pixels held (kernel slots + result register)
//     idle              : in_flight == 0
// -----------------------------------------------------------------------------
module fractal_scheduler #(
  parameter int PIPELINE_DEPTH = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 20
) (
  input  logic                                    clk,
  input  logic                                    rst,
  fractal_scheduler_if.slave                      bus,
  output logic                                    k_inc_enabled,
  output logic [DATA_WIDTH-1:0]                   k_zr_in,
  output logic [DATA_WIDTH-1:0]                   k_zi_in,
  output logic [DATA_WIDTH-1:0]                   k_cr_in,
  output logic [DATA_WIDTH-1:0]                   k_ci_in,
  output logic [7:0]                              k_iter_in,
  output logic                                    k_finished_in,
  input  logic [DATA_WIDTH-1:0]                   k_zr_out,
  input  logic [DATA_WIDTH-1:0]                   k_zi_out,
  input  logic [DATA_WIDTH-1:0]                   k_cr_out,
  input  logic [DATA_WIDTH-1:0]                   k_ci_out,
  input  logic [7:0]                              k_iter_out,
  input  logic                                    k_finished_out,
  output logic [$clog2(PIPELINE_DEPTH+2)-1:0]     in_flight,
  output logic                                    idle
);

  localparam int D  = PIPELINE_DEPTH;
  localparam int IW = $clog2(PIPELINE_DEPTH + 2);
  localparam logic [IW-1:0] IF_ONE = IW'(1);

  // ---------------------------------------------------------------------------
  // Shadow of the kernel pipeline: sv[i]/st[i] describe the pixel in kernel
  // stage i. sv[D-1]/st[D-1] belong to the kernel outputs seen this cycle.
  // ---------------------------------------------------------------------------
  logic [D-1:0]         sv;
  logic [TAG_WIDTH-1:0] st [D];

  logic                 sv_in;
  logic [TAG_WIDTH-1:0] st_in;

  // Result register and occupancy counter.
  logic                 m_valid_q;
  logic [TAG_WIDTH-1:0] m_tag_q;
  logic [7:0]           m_iter_q;
  logic [IW-1:0]        in_flight_q;

  // ---------------------------------------------------------------------------
  // Slot decision
  // ---------------------------------------------------------------------------
  logic rv;
  logic ofree;
  logic recirc;
  logic retire;
  logic park;
  logic slot_free;
  logic accept;
  logic pop;

  assign rv        = sv[D-1];
  assign ofree     = !m_valid_q || bus.m_ready;
  assign recirc    = rv && !k_finished_out;
  assign retire    = rv &&  k_finished_out &&  ofree;
  assign park      = rv &&  k_finished_out && !ofree;
  // A retiring pixel vacates its slot in the same cycle, so a new pixel can
  // take it immediately: one in and one out per cycle at steady state.
  assign slot_free = !rv || retire;
  assign accept    = bus.s_valid && slot_free;
  assign pop       = m_valid_q && bus.m_ready;

  assign bus.s_ready = slot_free;

  always_comb begin
    k_inc_enabled = 1'b0;
    k_zr_in       = '0;
    k_zi_in       = '0;
    k_cr_in       = '0;
    k_ci_in       = '0;
    k_iter_in     = '0;
    k_finished_in = 1'b1;
    sv_in         = 1'b0;
    st_in         = st[D-1];

    if (recirc) begin
      // Still iterating: feed the kernel its own result for another lap.
      k_zr_in       = k_zr_out;
      k_zi_in       = k_zi_out;
      k_cr_in       = k_cr_out;
      k_ci_in       = k_ci_out;
      k_iter_in     = k_iter_out;
      k_finished_in = 1'b0;
      k_inc_enabled = 1'b1;
      sv_in         = 1'b1;
    end else if (park) begin
      // Finished but the result register is busy: keep the pixel circulating
      // frozen (finished, no increment) and retry the retire next lap.
      k_zr_in       = k_zr_out;
      k_zi_in       = k_zi_out;
      k_cr_in       = k_cr_out;
      k_ci_in       = k_ci_out;
      k_iter_in     = k_iter_out;
      k_finished_in = 1'b1;
      k_inc_enabled = 1'b0;
      sv_in         = 1'b1;
    end else if (bus.s_valid) begin
      // Free slot (empty or just retired) taken by a new pixel, z starts at 0.
      k_cr_in       = bus.s_cr;
      k_ci_in       = bus.s_ci;
      k_finished_in = 1'b0;
      k_inc_enabled = 1'b1;
      sv_in         = 1'b1;
      st_in         = bus.s_tag;
    end
  end

  // ---------------------------------------------------------------------------
  // Shadow shift register. The kernel itself has no reset; clearing sv is
  // what makes whatever it still holds irrelevant.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sv <= '0;
      for (int i = 0; i < D; i++) begin
        st[i] <= '0;
      end
    end else begin
      sv    <= {sv[D-2:0], sv_in};
      st[0] <= st_in;
      for (int i = 1; i < D; i++) begin
        st[i] <= st[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_tag_q   <= '0;
      m_iter_q  <= '0;
    end else if (retire) begin
      m_valid_q <= 1'b1;
      m_tag_q   <= st[D-1];
      m_iter_q  <= k_iter_out;
    end else if (pop) begin
      m_valid_q <= 1'b0;
    end
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_tag   = m_tag_q;
  assign bus.m_iter  = m_iter_q;

  // ---------------------------------------------------------------------------
  // Occupancy: a retire moves a pixel from a slot into the result register,
  // so only accepts and result hand-offs change the count.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10:   in_flight_q <= in_flight_q + IF_ONE;
        2'b01:   in_flight_q <= in_flight_q - IF_ONE;
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  assign in_flight = in_flight_q;
  assign idle      = (in_flight_q == '0);

endmodule

// File: tb/tb_fractal_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fractal_scheduler
//   Bench for fractal_scheduler. Contains a behavioural fractal_kernel model
//   (PIPELINE_DEPTH register stages) so the scheduler runs in a closed loop.
//   Single-pixel cases come from a table of {c, tag, expected iter, expected
//   latency}; fill, backpressure and reset cases are hand-written sequences.
// -----------------------------------------------------------------------------
module tb_fractal_scheduler;

  localparam int D  = 9;
  localparam int DW = 32;
  localparam int TW = 20;
  localparam int IW = $clog2(D + 2);

  localparam logic [31:0] C_3P0  = 32'h3000_0000;
  localparam logic [31:0] C_2P0  = 32'h2000_0000;
  localparam logic [31:0] C_1P0  = 32'h1000_0000;
  localparam logic [31:0] C_M2P0 = 32'hE000_0000;
  localparam logic [31:0] C_M2P5 = 32'hD800_0000;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUT
  fractal_scheduler_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  logic          k_inc_enabled;
  logic [DW-1:0] k_zr_in, k_zi_in, k_cr_in, k_ci_in;
  logic [7:0]    k_iter_in;
  logic          k_finished_in;
  logic [DW-1:0] k_zr_out, k_zi_out, k_cr_out, k_ci_out;
  logic [7:0]    k_iter_out;
  logic          k_finished_out;
  logic [IW-1:0] in_flight;
  logic          idle;

  fractal_scheduler #(.PIPELINE_DEPTH(D), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .k_inc_enabled  (k_inc_enabled),
    .k_zr_in        (k_zr_in),
    .k_zi_in        (k_zi_in),
    .k_cr_in        (k_cr_in),
    .k_ci_in        (k_ci_in),
    .k_iter_in      (k_iter_in),
    .k_finished_in  (k_finished_in),
    .k_zr_out       (k_zr_out),
    .k_zi_out       (k_zi_out),
    .k_cr_out       (k_cr_out),
    .k_ci_out       (k_ci_out),
    .k_iter_out     (k_iter_out),
    .k_finished_out (k_finished_out),
    .in_flight      (in_flight),
    .idle           (idle)
  );

  // ---------------------------------------------------------------- kernel model
  // Escape test on the incoming z (|z|^2 > 4), z' = z^2 + c, iter' = iter + inc,
  // finished when escaped or iter' reaches 255. Finished inputs pass through.
  typedef struct packed {
    logic [31:0] zr;
    logic [31:0] zi;
    logic [31:0] cr;
    logic [31:0] ci;
    logic [7:0]  iter;
    logic        fin;
  } kstage_t;

  kstage_t kpipe [D];

  function automatic kstage_t kernel_step(input logic [31:0] zr, input logic [31:0] zi,
                                          input logic [31:0] cr, input logic [31:0] ci,
                                          input logic [7:0] iter, input logic fin,
                                          input logic inc);
    kstage_t r;
    longint  zr2, zi2, zri, mag, four;
    zr2  = longint'($signed(zr)) * longint'($signed(zr));
    zi2  = longint'($signed(zi)) * longint'($signed(zi));
    zri  = longint'($signed(zr)) * longint'($signed(zi));
    mag  = zr2 + zi2;
    four = longint'(4) <<< 56;
    r.cr = cr;
    r.ci = ci;
    if (fin) begin
      r.zr   = zr;
      r.zi   = zi;
      r.iter = iter;
      r.fin  = 1'b1;
    end else begin
      r.zr   = cr + 32'((zr2 - zi2) >>> 28);
      r.zi   = ci + 32'((2 * zri) >>> 28);
      r.iter = iter + {7'b0, inc};
      r.fin  = (mag > four) || (r.iter == 8'd255);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    kpipe[0] <= kernel_step(k_zr_in, k_zi_in, k_cr_in, k_ci_in,
                            k_iter_in, k_finished_in, k_inc_enabled);
    for (int i = 1; i < D; i++) kpipe[i] <= kpipe[i-1];
  end

  assign k_zr_out       = kpipe[D-1].zr;
  assign k_zi_out       = kpipe[D-1].zi;
  assign k_cr_out       = kpipe[D-1].cr;
  assign k_ci_out       = kpipe[D-1].ci;
  assign k_iter_out     = kpipe[D-1].iter;
  assign k_finished_out = kpipe[D-1].fin;

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [27:0] exp_q[$];   // {tag, iter} in expected retire order
  logic inflight_over = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got tag %0d iter %0d expected none",
                   bus.m_tag, bus.m_iter);
        end else begin
          logic [27:0] e;
          e = exp_q.pop_front();
          check("result_tag", longint'(bus.m_tag), longint'(e[27:8]));
          check("result_iter", longint'(bus.m_iter), longint'(e[7:0]));
        end
      end
      if (in_flight > IW'(D + 1)) inflight_over = 1'b1;
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input logic [31:0] cr, input logic [31:0] ci,
                             input logic [TW-1:0] tag);
    bus.s_valid = 1'b1;
    bus.s_cr    = cr;
    bus.s_ci    = ci;
    bus.s_tag   = tag;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int k = 0;
    while (!(idle && exp_q.size() == 0) && k < limit) begin
      step();
      k++;
    end
    check(name, longint'(k < limit), 1);
  endtask

  typedef struct {
    logic [31:0]   cr;
    logic [31:0]   ci;
    logic [TW-1:0] tag;
    logic [7:0]    iter;
    int            lat;
  } vec_t;

  vec_t vecs[8];

  task automatic run_single(input vec_t v);
    int k;
    check("single_ready", longint'(bus.s_ready), 1);
    drive_pixel(v.cr, v.ci, v.tag);
    exp_q.push_back({v.tag, v.iter});
    #1;
    check("inject_cr", longint'(k_cr_in), longint'(v.cr));
    check("inject_fin", longint'({k_finished_in, k_inc_enabled}), 1);
    step();
    bus.s_valid = 1'b0;
    k = 0;
    while (!bus.m_valid && k < 3000) begin
      step();
      k++;
    end
    check("latency", k, v.lat);
    check("in_flight_held", longint'(in_flight), 1);
    step();
    check("idle_after", longint'(idle), 1);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- test
  initial begin
    int k, j, stall, first_acc, last_acc, cyc;
    logic ok;

    vecs[0] = '{cr: C_3P0,  ci: 32'h0,   tag: 20'd5,  iter: 8'd2,   lat: 18};
    vecs[1] = '{cr: 32'h0,  ci: C_3P0,   tag: 20'd7,  iter: 8'd2,   lat: 18};
    vecs[2] = '{cr: C_2P0,  ci: 32'h0,   tag: 20'd9,  iter: 8'd3,   lat: 27};
    vecs[3] = '{cr: C_1P0,  ci: 32'h0,   tag: 20'd11, iter: 8'd4,   lat: 36};
    vecs[4] = '{cr: C_M2P5, ci: 32'h0,   tag: 20'd13, iter: 8'd2,   lat: 18};
    vecs[5] = '{cr: C_1P0,  ci: C_1P0,   tag: 20'd15, iter: 8'd3,   lat: 27};
    vecs[6] = '{cr: 32'h0,  ci: 32'h0,   tag: 20'd1,  iter: 8'd255, lat: 255 * D};
    vecs[7] = '{cr: C_M2P0, ci: 32'h0,   tag: 20'd2,  iter: 8'd255, lat: 255 * D};

    bus.s_valid = 1'b0;
    bus.s_cr    = '0;
    bus.s_ci    = '0;
    bus.s_tag   = '0;
    bus.m_ready = 1'b1;

    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset / idle state
    check("rst_s_ready",   longint'(bus.s_ready), 1);
    check("rst_m_valid",   longint'(bus.m_valid), 0);
    check("rst_m_tag",     longint'(bus.m_tag), 0);
    check("rst_m_iter",    longint'(bus.m_iter), 0);
    check("rst_idle",      longint'(idle), 1);
    check("rst_in_flight", longint'(in_flight), 0);
    check("rst_k_fin_in",  longint'(k_finished_in), 1);
    check("rst_k_inc",     longint'(k_inc_enabled), 0);

    // Table-driven single pixels
    for (int i = 0; i < 8; i++) run_single(vecs[i]);

    // Fill: 9 pixels back to back, then refill while the first batch retires
    for (int i = 0; i < D; i++) begin
      drive_pixel(C_3P0, 32'h0, TW'(i));
      check("fill_ready", longint'(bus.s_ready), 1);
      exp_q.push_back({TW'(i), 8'd2});
      step();
    end
    drive_pixel(C_3P0, 32'h0, TW'(100));
    check("full_ready_low", longint'(bus.s_ready), 0);
    check("in_flight_full", longint'(in_flight), D);
    stall = 0;
    j = 0;
    cyc = 0;
    first_acc = -1;
    last_acc = -1;
    while (j < D && cyc < 100) begin
      bus.s_tag = TW'(100 + j);
      if (bus.s_ready) begin
        exp_q.push_back({TW'(100 + j), 8'd2});
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        j++;
      end else if (j == 0) begin
        stall++;
      end
      step();
      cyc++;
    end
    bus.s_valid = 1'b0;
    check("fill_stall_cycles", stall, D);
    check("refill_span", last_acc - first_acc, D - 1);
    wait_drain("fill_drain", 200);

    // Backpressure: one result held, the second parked until release
    bus.m_ready = 1'b0;
    drive_pixel(C_3P0, 32'h0, TW'(20));
    exp_q.push_back({TW'(20), 8'd2});
    step();
    drive_pixel(C_3P0, 32'h0, TW'(21));
    exp_q.push_back({TW'(21), 8'd2});
    step();
    bus.s_valid = 1'b0;
    k = 0;
    while (!bus.m_valid && k < 40) begin
      step();
      k++;
    end
    check("bp_first_latency", k, 17);
    ok = 1'b1;
    for (int i = 0; i < 19; i++) begin
      step();
      if (!(bus.m_valid && bus.m_tag == TW'(20) && bus.m_iter == 8'd2)) ok = 1'b0;
      if (in_flight != IW'(2)) ok = 1'b0;
    end
    check("bp_hold_stable", longint'(ok), 1);
    bus.m_ready = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.m_valid && k < 30);
    check("bp_release_latency", k, D);
    check("bp_second_tag", longint'(bus.m_tag), 21);
    wait_drain("bp_drain", 100);

    // Reset with a held result and four pixels still iterating
    bus.m_ready = 1'b0;
    drive_pixel(C_3P0, 32'h0, TW'(40));
    step();
    for (int i = 0; i < 4; i++) begin
      drive_pixel(32'h0, 32'h0, TW'(41 + i));
      step();
    end
    bus.s_valid = 1'b0;
    k = 0;
    while (!bus.m_valid && k < 40) begin
      step();
      k++;
    end
    check("pre_rst_in_flight", longint'(in_flight), 5);
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid",   longint'(bus.m_valid), 0);
    check("mid_rst_in_flight", longint'(in_flight), 0);
    check("mid_rst_idle",      longint'(idle), 1);
    step();
    step();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3 * D; i++) begin
      step();
      if (bus.m_valid || !idle || !bus.s_ready) ok = 1'b0;
    end
    check("no_stale_after_rst", longint'(ok), 1);

    check("queue_empty", exp_q.size(), 0);
    check("in_flight_bound", longint'(inflight_over), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fractal_scheduler.md
Name: fractal_scheduler

Overview:
Slot scheduler that time-multiplexes one fractal_kernel pipeline (latency PIPELINE_DEPTH) among many pixels. Each cycle it owns one issue slot: the return from the kernel is recirculated, retired to the result port, or replaced by a new pixel from the input stream. It tracks per-slot valid/tag in a shadow shift register aligned to the kernel latency. Sits between the pixel-coordinate generator and the colour/pixel writer.

Parameters:
PIPELINE_DEPTH, 9, kernel latency in cycles; shadow register length
DATA_WIDTH, 32, signed Q4.28 width of z/c, matches kernel INPUT_DATA_WIDTH
TAG_WIDTH, 20, pixel tag (index) width carried alongside each slot

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
s_valid  in  1  new pixel available
s_ready  out  1  pixel accepted on clk edge when s_valid && s_ready
s_cr  in  DATA_WIDTH  Re(c) of new pixel
s_ci  in  DATA_WIDTH  Im(c) of new pixel
s_tag  in  TAG_WIDTH  pixel tag
m_valid  out  1  result valid (registered)
m_ready  in  1  result consumer ready
m_tag  out  TAG_WIDTH  tag of retired pixel
m_iter  out  8  final iteration count
k_inc_enabled  out  1  to kernel inc_enabled
k_zr_in, k_zi_in, k_cr_in, k_ci_in  out  DATA_WIDTH each  to kernel inputs
k_iter_in  out  8  to kernel iter_in
k_finished_in  out  1  to kernel finished_in
k_zr_out, k_zi_out, k_cr_out, k_ci_out  in  DATA_WIDTH each  from kernel outputs
k_iter_out  in  8  from kernel
k_finished_out  in  1  from kernel
in_flight  out  $clog2(PIPELINE_DEPTH+2)  valid pixels held (slots + output register)
idle  out  1  in_flight == 0

Behaviour:
- Shadow: sv[0..D-1] valid bits, st[0..D-1] tags, D=PIPELINE_DEPTH; shift every cycle; sv[D-1]/st[D-1] align with kernel outputs of the same cycle. Return slot rv=sv[D-1].
- Reset: sv all 0, m_valid=0, m_tag=0, m_iter=0, in_flight=0, idle=1. Kernel has no reset; its contents are ignored via sv. Reset mid-operation discards all in-flight pixels and any held result.
- Output register free (ofree) = !m_valid || m_ready.
- Slot decision, combinational, priority order:
  1. rv && !k_finished_out: recirculate. k_* inputs = k_* outputs, k_finished_in=0, k_inc_enabled=1, sv[0]<=1, tag kept.
  2. rv && k_finished_out && ofree: retire. m_valid<=1, m_tag<=st[D-1], m_iter<=k_iter_out. Slot becomes free -> case 4.
  3. rv && k_finished_out && !ofree: park. Recirculate with k_finished_in=1, k_inc_enabled=0; iter held, z values don't care. Retire retried next lap.
  4. slot free (rv=0 or retired): s_ready=1. If s_valid: inject k_zr_in=0, k_zi_in=0, k_cr_in=s_cr, k_ci_in=s_ci, k_iter_in=0, k_finished_in=0, k_inc_enabled=1, sv[0]<=1, st[0]<=s_tag. Else drive zeros, k_finished_in=1, k_inc_enabled=0, sv[0]<=0.
- s_ready is combinational from rv, k_finished_out, m_valid, m_ready; never depends on s_valid.
- If m_valid && m_ready and no retire this cycle, m_valid<=0.
- Simultaneous retire and inject in one cycle is required (full throughput: one pixel in and one out per cycle at steady state).
- Escape/max-iter criteria live in the kernel (|z|^2 > 4.0 or iter==255); scheduler only acts on k_finished_out.
- Latency: pixel accepted on edge t and finishing on pass n: m_valid high after edge t+n*D.
- in_flight: +1 on accept, -1 on m_valid&&m_ready; both -> unchanged. Max D+1.
- Results leave out of order; consumers use m_tag.

Test Plan:
- Reset, idle: s_ready=1, m_valid=0, idle=1, in_flight=0, k_finished_in=1.
- Single pixel c=3.0 (cr=0x3000_0000, ci=0), tag 5, D=9 -> m_valid 18 cycles after accept, m_tag=5, m_iter=2.
- c=0 tag 1 -> m_iter=255 after 255 laps; c=-2.0 (0xE000_0000) -> m_iter=255 (periodic orbit).
- Fill: 9 consecutive pixels, c=3.0 tags 0..8 -> s_ready=0 on 10th cycle; results in tag order 0..8 back-to-back, iter 2 each; refilling while retiring sustains 1/cycle.
- Backpressure: m_ready=0 with two finished pixels -> first held in m_* stable, second parked (iter unchanged); release m_ready -> second emitted exactly D cycles later, m_iter=2, in_flight never >D+1.
- Assert rst with 4 pixels in flight -> m_valid=0, in_flight=0 immediately; no stale results after deassert over 3*D cycles.
